rv32i_multicycle_controller: RTL and testbench
==============================================

Name: rv32i_multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback around the shared datapath: instruction decoder, register file, ALU, PC register and a single memory port.
- Consumes the decoded opcode and funct3 from the instruction register.
- Drives all datapath enables and mux selects, plus the instruction and data memory request/acknowledge handshakes.

Parameters:
- FENCE_AS_NOP, 1, when 1 opcode 0001111 retires as a NOP (PC+4); when 0 it traps as illegal.

Ports:
- i_Clock  in  1  system clock, all state changes on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_OP  in  7  opcode field of the instruction register
- i_Funct3  in  3  funct3 field of the instruction register
- i_BranchTaken  in  1  branch comparator result for the current instruction
- i_IMemAck  in  1  instruction read complete; data valid this cycle
- i_DMemAck  in  1  data access complete; load data valid this cycle
- o_IMemReq  out  1  instruction fetch request at current PC
- o_DMemReq  out  1  data memory request at ALU result address
- o_DMemWrite  out  1  qualifies o_DMemReq as a store
- o_IRLoad  out  1  load instruction register
- o_PCLoad  out  1  load PC from o_PCSel source
- o_PCSel  out  2  0 = PC+4, 1 = PC+IMM, 2 = ALU result with bit 0 cleared
- o_ALUSrcA  out  2  0 = RS1, 1 = PC, 2 = zero
- o_ALUSrcB  out  1  0 = RS2, 1 = IMM
- o_RegWrite  out  1  register file write enable
- o_WBSel  out  2  0 = ALU result, 1 = load data, 2 = PC+4
- o_Illegal  out  1  sticky illegal-instruction flag
- o_State  out  3  current state code, for debug and verification

Behaviour:
- States and codes: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, TRAP = 5. Codes 6–7 are unreachable and recover to FETCH.
- Reset:
  - i_Reset high on a clock edge sets state to FETCH and clears o_Illegal.
  - While i_Reset is high, every output is 0.
  - Reset mid-operation abandons any pending request; no PC or register write occurs.
- Outputs are combinational from state, i_OP, i_Funct3, i_BranchTaken and the ack inputs. Any signal not listed for a state is 0.
- FETCH:
  - o_IMemReq = 1 until i_IMemAck.
  - In the ack cycle: o_IRLoad = 1, then go to DECODE.
  - Zero-wait memory means ack in the first cycle.
- DECODE: classify the instruction.
  - Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR (funct3 must be 000), 1100011 BRANCH (funct3 not 010 or 011), 0000011 LOAD (funct3 in {000, 001, 010, 100, 101}), 0100011 STORE (funct3 in {000, 001, 010}), 0010011 OP-IMM, 0110011 OP.
  - FENCE with FENCE_AS_NOP = 1: o_PCLoad = 1, o_PCSel = 0, go to FETCH.
  - Any other opcode or funct3 goes to TRAP. Otherwise go to EXECUTE.
- EXECUTE:
  - OP: SrcA = 0, SrcB = 0.
  - OP-IMM, LOAD, STORE, JALR: SrcA = 0, SrcB = 1.
  - AUIPC: SrcA = 1, SrcB = 1.
  - LUI: SrcA = 2, SrcB = 1.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR go to WRITEBACK.
  - LOAD and STORE go to MEMORY.
  - BRANCH: o_PCLoad = 1, o_PCSel = i_BranchTaken ? 1 : 0, go to FETCH.
- MEMORY:
  - o_DMemReq = 1 and o_DMemWrite = (STORE), both held stable until i_DMemAck.
  - On ack, a LOAD goes to WRITEBACK.
  - On ack, a STORE asserts o_PCLoad = 1 with PCSel = 0 and goes to FETCH.
- WRITEBACK: one cycle with o_RegWrite = 1 and o_PCLoad = 1, then go to FETCH.
  - JAL: WBSel = 2, PCSel = 1.
  - JALR: WBSel = 2, PCSel = 2, and SrcA/SrcB held as in EXECUTE.
  - LOAD: WBSel = 1.
  - Others: WBSel = 0, PCSel = 0.
- TRAP:
  - o_Illegal = 1, with no requests, no PC load and no register write.
  - The FSM stays in TRAP until reset.
- Cycle counts with zero-wait memory: ALU, LUI, AUIPC and jump instructions take 4 cycles; LOAD takes 5; STORE takes 4; BRANCH takes 3; FENCE takes 2.
- Each memory wait state adds exactly 1 cycle.
- Exactly one o_PCLoad pulse per retired instruction; never more than one o_RegWrite pulse per instruction.

Test Plan:
- Reset for 2 cycles, then ADDI (i_OP = 0010011, funct3 = 000), acks tied to 1 → o_State sequence 0,1,2,4,0; o_RegWrite = 1 only in cycle 4 with WBSel = 0; a single o_PCLoad with PCSel = 0.
- LW (0000011, funct3 = 010) with i_DMemAck delayed 3 cycles → o_DMemReq high for 4 cycles with o_DMemWrite = 0; WRITEBACK with WBSel = 1; total 8 cycles.
- BEQ with i_BranchTaken = 1, then again with 0 → EXECUTE gives o_PCLoad = 1 with PCSel = 1 and PCSel = 0 respectively; no o_RegWrite; 3 cycles each.
- JALR (1100111, funct3 = 000), then JALR with funct3 = 001 → first: WRITEBACK with WBSel = 2, PCSel = 2; second: TRAP with o_Illegal = 1 held 10 cycles, then reset clears it and state returns to 0.
- SW (0100011, funct3 = 010) with i_Reset asserted in the second MEMORY wait cycle → next cycle all outputs 0, state = 0, no o_PCLoad issued.
- FENCE (0001111) with FENCE_AS_NOP = 1 and with FENCE_AS_NOP = 0 → 2-cycle retire with PCSel = 0 in the first case; TRAP in the second.

Source files
------------

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller
//   Multi-cycle control FSM for an RV32I core. Steps each instruction through
//   FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK around a shared datapath and
//   a single memory port.
//
// Parameters
//   FENCE_AS_NOP   1: opcode 0001111 retires as a NOP (PC+4); 0: it traps.
//
// Ports
//   i_Clock        system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_OP           opcode field of the instruction register
//   i_Funct3       funct3 field of the instruction register
//   i_BranchTaken  branch comparator result
//   i_IMemAck      instruction read complete
//   i_DMemAck      data access complete
//   o_IMemReq      instruction fetch request
//   o_DMemReq      data memory request
//   o_DMemWrite    qualifies o_DMemReq as a store
//   o_IRLoad       load instruction register
//   o_PCLoad       load PC from the o_PCSel source
//   o_PCSel        0 = PC+4, 1 = PC+IMM, 2 = ALU result & ~1
//   o_ALUSrcA      0 = RS1, 1 = PC, 2 = zero
//   o_ALUSrcB      0 = RS2, 1 = IMM
//   o_RegWrite     register file write enable
//   o_WBSel        0 = ALU, 1 = load data, 2 = PC+4
//   o_Illegal      illegal-instruction flag, held until reset
//   o_State        current state code
module rv32i_multicycle_controller #(
    parameter bit FENCE_AS_NOP = 1'b1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [6:0] i_OP,
    input  logic [2:0] i_Funct3,
    input  logic       i_BranchTaken,
    input  logic       i_IMemAck,
    input  logic       i_DMemAck,
    output logic       o_IMemReq,
    output logic       o_DMemReq,
    output logic       o_DMemWrite,
    output logic       o_IRLoad,
    output logic       o_PCLoad,
    output logic [1:0] o_PCSel,
    output logic [1:0] o_ALUSrcA,
    output logic       o_ALUSrcB,
    output logic       o_RegWrite,
    output logic [1:0] o_WBSel,
    output logic       o_Illegal,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcPlusImm = 2'd1;
    localparam logic [1:0] PcAlu    = 2'd2;

    localparam logic [1:0] SrcARs1  = 2'd0;
    localparam logic [1:0] SrcAPc   = 2'd1;
    localparam logic [1:0] SrcAZero = 2'd2;

    localparam logic [1:0] WbAlu    = 2'd0;
    localparam logic [1:0] WbLoad   = 2'd1;
    localparam logic [1:0] WbPc4    = 2'd2;

    state_e state_q, state_d;
    logic   legal;
    logic   fence_nop;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode/funct3 legality for everything except FENCE, handled separately.
    always_comb begin
        legal = 1'b0;
        case (i_OP)
            OpLui, OpAuipc, OpJal, OpImm, OpReg: legal = 1'b1;
            OpJalr:   legal = (i_Funct3 == 3'b000);
            OpBranch: legal = (i_Funct3 != 3'b010) && (i_Funct3 != 3'b011);
            OpLoad:   legal = i_Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OpStore:  legal = i_Funct3 inside {3'b000, 3'b001, 3'b010};
            default:  legal = 1'b0;
        endcase
    end

    assign fence_nop = FENCE_AS_NOP && (i_OP == OpFence);

    always_comb begin
        state_d     = state_q;
        o_IMemReq   = 1'b0;
        o_DMemReq   = 1'b0;
        o_DMemWrite = 1'b0;
        o_IRLoad    = 1'b0;
        o_PCLoad    = 1'b0;
        o_PCSel     = PcPlus4;
        o_ALUSrcA   = SrcARs1;
        o_ALUSrcB   = 1'b0;
        o_RegWrite  = 1'b0;
        o_WBSel     = WbAlu;
        o_Illegal   = 1'b0;
        o_State     = state_q;

        case (state_q)
            StFetch: begin
                o_IMemReq = 1'b1;
                if (i_IMemAck) begin
                    o_IRLoad = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (fence_nop) begin
                    o_PCLoad = 1'b1;
                    o_PCSel  = PcPlus4;
                    state_d  = StFetch;
                end else if (legal) begin
                    state_d = StExecute;
                end else begin
                    state_d = StTrap;
                end
            end
            StExecute: begin
                case (i_OP)
                    OpReg: begin
                        state_d = StWriteback;
                    end
                    OpImm, OpJalr: begin
                        o_ALUSrcB = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpLoad, OpStore: begin
                        o_ALUSrcB = 1'b1;
                        state_d   = StMemory;
                    end
                    OpAuipc: begin
                        o_ALUSrcA = SrcAPc;
                        o_ALUSrcB = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpLui: begin
                        o_ALUSrcA = SrcAZero;
                        o_ALUSrcB = 1'b1;
                        state_d   = StWriteback;
                    end
                    OpJal: begin
                        state_d = StWriteback;
                    end
                    OpBranch: begin
                        o_PCLoad = 1'b1;
                        o_PCSel  = i_BranchTaken ? PcPlusImm : PcPlus4;
                        state_d  = StFetch;
                    end
                    // IR is stable from DECODE, so this only guards corruption.
                    default: state_d = StTrap;
                endcase
            end
            StMemory: begin
                o_DMemReq   = 1'b1;
                o_DMemWrite = (i_OP == OpStore);
                if (i_DMemAck) begin
                    if (i_OP == OpStore) begin
                        o_PCLoad = 1'b1;
                        o_PCSel  = PcPlus4;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end
            end
            StWriteback: begin
                o_RegWrite = 1'b1;
                o_PCLoad   = 1'b1;
                state_d    = StFetch;
                case (i_OP)
                    OpJal: begin
                        o_WBSel = WbPc4;
                        o_PCSel = PcPlusImm;
                    end
                    OpJalr: begin
                        // ALU must still produce rs1+imm for the jump target.
                        o_WBSel   = WbPc4;
                        o_PCSel   = PcAlu;
                        o_ALUSrcA = SrcARs1;
                        o_ALUSrcB = 1'b1;
                    end
                    OpLoad:  o_WBSel = WbLoad;
                    default: o_WBSel = WbAlu;
                endcase
            end
            StTrap: begin
                o_Illegal = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset silences every output in the same cycle it is asserted.
        if (i_Reset) begin
            o_IMemReq   = 1'b0;
            o_DMemReq   = 1'b0;
            o_DMemWrite = 1'b0;
            o_IRLoad    = 1'b0;
            o_PCLoad    = 1'b0;
            o_PCSel     = 2'd0;
            o_ALUSrcA   = 2'd0;
            o_ALUSrcB   = 1'b0;
            o_RegWrite  = 1'b0;
            o_WBSel     = 2'd0;
            o_Illegal   = 1'b0;
            o_State     = 3'd0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Scoreboard bench for rv32i_multicycle_controller. The stimulus process drives
// one cycle at a time and queues the expected output vector of both DUTs
// (FENCE_AS_NOP = 1 and 0); a monitor pops and compares on each falling edge.
module tb_rv32i_multicycle_controller;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_write;
        logic       ir_load;
        logic       pc_load;
        logic [1:0] pc_sel;
        logic [1:0] src_a;
        logic       src_b;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        outs_t e0;
        outs_t e1;
        string name;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic       taken = 1'b0;
    logic       imack = 1'b0;
    logic       dmack = 1'b0;

    logic       o0_imem_req, o0_dmem_req, o0_dmem_write, o0_ir_load, o0_pc_load;
    logic [1:0] o0_pc_sel, o0_src_a, o0_wb_sel;
    logic       o0_src_b, o0_reg_write, o0_illegal;
    logic [2:0] o0_state;
    logic       o1_imem_req, o1_dmem_req, o1_dmem_write, o1_ir_load, o1_pc_load;
    logic [1:0] o1_pc_sel, o1_src_a, o1_wb_sel;
    logic       o1_src_b, o1_reg_write, o1_illegal;
    logic [2:0] o1_state;

    outs_t act0, act1;
    assign act0 = {o0_imem_req, o0_dmem_req, o0_dmem_write, o0_ir_load, o0_pc_load, o0_pc_sel,
                   o0_src_a, o0_src_b, o0_reg_write, o0_wb_sel, o0_illegal, o0_state};
    assign act1 = {o1_imem_req, o1_dmem_req, o1_dmem_write, o1_ir_load, o1_pc_load, o1_pc_sel,
                   o1_src_a, o1_src_b, o1_reg_write, o1_wb_sel, o1_illegal, o1_state};

    int checks = 0;
    int errors = 0;
    item_t sb_q[$];

    always #5 clk = ~clk;

    rv32i_multicycle_controller #(.FENCE_AS_NOP(1'b1)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_OP(op), .i_Funct3(f3), .i_BranchTaken(taken),
        .i_IMemAck(imack), .i_DMemAck(dmack),
        .o_IMemReq(o0_imem_req), .o_DMemReq(o0_dmem_req), .o_DMemWrite(o0_dmem_write),
        .o_IRLoad(o0_ir_load), .o_PCLoad(o0_pc_load), .o_PCSel(o0_pc_sel),
        .o_ALUSrcA(o0_src_a), .o_ALUSrcB(o0_src_b), .o_RegWrite(o0_reg_write),
        .o_WBSel(o0_wb_sel), .o_Illegal(o0_illegal), .o_State(o0_state)
    );

    rv32i_multicycle_controller #(.FENCE_AS_NOP(1'b0)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_OP(op), .i_Funct3(f3), .i_BranchTaken(taken),
        .i_IMemAck(imack), .i_DMemAck(dmack),
        .o_IMemReq(o1_imem_req), .o_DMemReq(o1_dmem_req), .o_DMemWrite(o1_dmem_write),
        .o_IRLoad(o1_ir_load), .o_PCLoad(o1_pc_load), .o_PCSel(o1_pc_sel),
        .o_ALUSrcA(o1_src_a), .o_ALUSrcB(o1_src_b), .o_RegWrite(o1_reg_write),
        .o_WBSel(o1_wb_sel), .o_Illegal(o1_illegal), .o_State(o1_state)
    );

    // Monitor: one expected item per cycle, compared away from the rising edge.
    always @(negedge clk) begin : monitor
        item_t it;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (act0 !== it.e0) begin
                errors++;
                $display("FAIL %s dut0: got %b want %b", it.name, act0, it.e0);
            end
            checks++;
            if (act1 !== it.e1) begin
                errors++;
                $display("FAIL %s dut1: got %b want %b", it.name, act1, it.e1);
            end
        end
    end

    // Field order: state, imem_req, dmem_req, dmem_write, ir_load, pc_load,
    // pc_sel, src_a, src_b, reg_write, wb_sel, illegal.
    function automatic outs_t ex(input logic [2:0] st, input logic imr, input logic dmr,
                                 input logic dmw, input logic irl, input logic pcl,
                                 input logic [1:0] pcs, input logic [1:0] sa, input logic sb,
                                 input logic rw, input logic [1:0] wb, input logic ill);
        outs_t o;
        o.imem_req = imr; o.dmem_req = dmr; o.dmem_write = dmw; o.ir_load = irl;
        o.pc_load = pcl; o.pc_sel = pcs; o.src_a = sa; o.src_b = sb; o.reg_write = rw;
        o.wb_sel = wb; o.illegal = ill; o.state = st;
        return o;
    endfunction

    function automatic outs_t zero_out();
        return ex(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0);
    endfunction

    task automatic step2(input string name, input logic r, input logic ia, input logic da,
                         input logic bt, input logic [6:0] o, input logic [2:0] f,
                         input outs_t e0, input outs_t e1);
        item_t it;
        rst = r; imack = ia; dmack = da; taken = bt; op = o; f3 = f;
        it.e0 = e0; it.e1 = e1; it.name = name;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic r, input logic ia, input logic da,
                        input logic bt, input logic [6:0] o, input logic [2:0] f,
                        input outs_t e);
        step2(name, r, ia, da, bt, o, f, e, e);
    endtask

    task automatic fetch_decode(input string name, input logic [6:0] o, input logic [2:0] f);
        step({name, "_fetch"}, 0, 1, 1, 0, o, f, ex(3'd0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step({name, "_decode"}, 0, 1, 1, 0, o, f, ex(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
    endtask

    // Four-cycle register-writing instruction (ALU ops, LUI, AUIPC, jumps).
    task automatic run_wb(input string name, input logic [6:0] o, input logic [2:0] f,
                          input logic [1:0] sa, input logic sb, input logic [1:0] wb,
                          input logic [1:0] pcs);
        logic [1:0] wsa;
        logic       wsb;
        wsa = (o == OpJalr) ? sa : 2'd0;
        wsb = (o == OpJalr) ? sb : 1'b0;
        fetch_decode(name, o, f);
        step({name, "_exec"}, 0, 1, 1, 0, o, f, ex(3'd2, 0, 0, 0, 0, 0, 2'd0, sa, sb, 0, 2'd0, 0));
        step({name, "_wb"}, 0, 1, 1, 0, o, f, ex(3'd4, 0, 0, 0, 0, 1, pcs, wsa, wsb, 1, wb, 0));
    endtask

    task automatic run_load(input string name, input logic [2:0] f, input int waits);
        fetch_decode(name, OpLoad, f);
        step({name, "_exec"}, 0, 1, 1, 0, OpLoad, f,
             ex(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 0));
        for (int i = 0; i < waits; i++)
            step({name, "_memwait"}, 0, 1, 0, 0, OpLoad, f,
                 ex(3'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step({name, "_memack"}, 0, 1, 1, 0, OpLoad, f,
             ex(3'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step({name, "_wb"}, 0, 1, 1, 0, OpLoad, f,
             ex(3'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 1, 2'd1, 0));
    endtask

    task automatic run_store(input string name, input logic [2:0] f, input int waits);
        fetch_decode(name, OpStore, f);
        step({name, "_exec"}, 0, 1, 1, 0, OpStore, f,
             ex(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 0));
        for (int i = 0; i < waits; i++)
            step({name, "_memwait"}, 0, 1, 0, 0, OpStore, f,
                 ex(3'd3, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step({name, "_memack"}, 0, 1, 1, 0, OpStore, f,
             ex(3'd3, 0, 1, 1, 0, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0));
    endtask

    task automatic run_branch(input string name, input logic [2:0] f, input logic bt);
        fetch_decode(name, OpBranch, f);
        step({name, "_exec"}, 0, 1, 1, bt, OpBranch, f,
             ex(3'd2, 0, 0, 0, 0, 1, {1'b0, bt}, 2'd0, 0, 0, 2'd0, 0));
    endtask

    task automatic run_trap(input string name, input logic [6:0] o, input logic [2:0] f,
                            input int hold);
        fetch_decode(name, o, f);
        for (int i = 0; i < hold; i++)
            step({name, "_trap"}, 0, 1, 1, 0, o, f,
                 ex(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1));
        step({name, "_reset"}, 1, 1, 1, 0, o, f, zero_out());
        // Fetch stalled so FETCH is observed with the flag cleared.
        step({name, "_after_reset"}, 0, 0, 0, 0, o, f,
             ex(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset0", 1, 1, 1, 0, OpImm, 3'd0, zero_out());
        step("reset1", 1, 1, 1, 0, OpImm, 3'd0, zero_out());

        run_wb("addi", OpImm, 3'b000, 2'd0, 1, 2'd0, 2'd0);
        run_load("lw", 3'b010, 3);
        run_branch("beq_taken", 3'b000, 1'b1);
        run_branch("beq_not_taken", 3'b000, 1'b0);
        run_wb("jalr", OpJalr, 3'b000, 2'd0, 1, 2'd2, 2'd2);
        run_wb("add", OpReg, 3'b000, 2'd0, 0, 2'd0, 2'd0);
        step("lui_fetch_wait", 0, 0, 1, 0, OpLui, 3'd0,
             ex(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        run_wb("lui", OpLui, 3'b000, 2'd2, 1, 2'd0, 2'd0);
        run_wb("auipc", OpAuipc, 3'b000, 2'd1, 1, 2'd0, 2'd0);
        run_wb("jal", OpJal, 3'b000, 2'd0, 0, 2'd2, 2'd1);
        run_store("sw_wait1", 3'b010, 1);
        run_store("sb", 3'b000, 0);
        run_load("lbu", 3'b100, 0);

        run_trap("jalr_bad", OpJalr, 3'b001, 10);
        run_trap("load_bad", OpLoad, 3'b011, 2);
        run_trap("branch_bad", OpBranch, 3'b010, 1);

        // SW with reset landing in its second memory wait cycle.
        fetch_decode("sw_rst", OpStore, 3'b010);
        step("sw_rst_exec", 0, 1, 0, 0, OpStore, 3'b010,
             ex(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 0));
        step("sw_rst_memwait", 0, 1, 0, 0, OpStore, 3'b010,
             ex(3'd3, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step("sw_rst_assert", 1, 1, 1, 0, OpStore, 3'b010, zero_out());
        step("sw_rst_next", 1, 1, 1, 0, OpStore, 3'b010, zero_out());
        step("sw_rst_fetch", 0, 0, 0, 0, OpStore, 3'b010,
             ex(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));

        // FENCE: dut0 retires in two cycles, dut1 traps.
        step("fence_fetch", 0, 1, 1, 0, OpFence, 3'd0,
             ex(3'd0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        step2("fence_decode", 0, 0, 1, 0, OpFence, 3'd0,
              ex(3'd1, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 2'd0, 0),
              ex(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0));
        for (int i = 0; i < 3; i++)
            step2("fence_after", 0, 0, 1, 0, OpFence, 3'd0,
                  ex(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 0),
                  ex(3'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 1));

        // Give the monitor a bounded window to drain the scoreboard.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
